// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Captures the winner's byte, pulses tx_start, then follows the Tx busy/done handshake.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned BUSY_TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_start,
    input  logic                          tx_busy,
    input  logic                          tx_done,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          arb_busy,
    output logic                          timeout_err
);

    localparam int unsigned IDW  = $clog2(NUM_REQ);
    localparam int unsigned CNTW = ($clog2(BUSY_TIMEOUT) > 0) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BUSY_TIMEOUT - 1);
    localparam logic [IDW-1:0]  LAST_ID  = IDW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [CNTW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic [IDW-1:0]          grant_q, grant_d;
    logic [NUM_REQ-1:0]      ack_q, ack_d;
    logic                    start_q, start_d;
    logic                    abusy_q, abusy_d;
    logic                    terr_q, terr_d;

    logic                    win_found;
    logic [IDW-1:0]          win_id;
    logic [DATA_WIDTH-1:0]   win_data;

    // Search upward from rr_ptr with explicit wrap so non-power-of-two counts never overflow.
    always_comb begin
        int unsigned idx;
        logic [IDW-1:0] cand;
        idx       = 0;
        cand      = '0;
        win_found = 1'b0;
        win_id    = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = 32'(rr_ptr_q) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = IDW'(idx);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
        win_data = req_data[32'(win_id)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        ack_d     = '0;
        start_d   = 1'b0;
        terr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    tx_data_d = win_data;
                    grant_d   = win_id;
                    ack_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
                    start_d   = 1'b1;
                    rr_ptr_d  = (win_id == LAST_ID) ? '0 : win_id + 1'b1;
                    cnt_d     = '0;
                    state_d   = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // A done pulse wins over busy so a very short frame still completes.
                if (tx_done) begin
                    state_d = IDLE;
                end else if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    terr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        abusy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            tx_data_q <= '0;
            grant_q   <= '0;
            ack_q     <= '0;
            start_q   <= 1'b0;
            abusy_q   <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            start_q   <= start_d;
            abusy_q   <= abusy_d;
            terr_q    <= terr_d;
        end
    end

    assign req_ack     = ack_q;
    assign tx_data     = tx_data_q;
    assign tx_start    = start_q;
    assign grant_id    = grant_q;
    assign arb_busy    = abusy_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed vector table, corner sequences,
// and randomized traffic compared against a transaction-level reference model.
module tb_uart_tx_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned BT = 12;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NR-1:0]  req_valid = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR-1:0]  req_ack;
    logic [DW-1:0]  tx_data;
    logic           tx_start;
    logic           tx_busy = 1'b0;
    logic           tx_done = 1'b0;
    logic [1:0]     grant_id;
    logic           arb_busy;
    logic           timeout_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ(NR),
        .DATA_WIDTH(DW),
        .BUSY_TIMEOUT(BT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ack(req_ack),
        .tx_data(tx_data),
        .tx_start(tx_start),
        .tx_busy(tx_busy),
        .tx_done(tx_done),
        .grant_id(grant_id),
        .arb_busy(arb_busy),
        .timeout_err(timeout_err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a frame is "in flight" from grant until done/timeout;
    // timeout measured by absolute cycle distance from the grant edge.
    int unsigned m_ptr = 0;
    int unsigned m_cyc = 0;
    int unsigned m_grant_cyc = 0;
    bit          m_inflight = 0;
    bit          m_started = 0;
    logic [NR-1:0] e_ack = '0;
    logic        e_start = 0;
    logic [DW-1:0] e_data = '0;
    logic [1:0]  e_gid = '0;
    logic        e_abusy = 0;
    logic        e_terr = 0;

    task automatic model_step();
        bit found;
        int unsigned w;
        m_cyc++;
        if (reset) begin
            m_ptr = 0; m_inflight = 0; m_started = 0;
            e_ack = '0; e_start = 0; e_data = '0; e_gid = '0; e_abusy = 0; e_terr = 0;
        end else begin
            e_ack = '0; e_start = 0; e_terr = 0;
            if (!m_inflight) begin
                found = 0;
                for (int k = 0; k < NR; k++) begin
                    w = (m_ptr + k) % NR;
                    if (!found && req_valid[w]) begin
                        found = 1;
                        e_data = req_data[w*DW +: DW];
                        e_gid = 2'(w);
                        e_ack = NR'(1) << w;
                        e_start = 1;
                        m_ptr = (w + 1) % NR;
                        m_inflight = 1;
                        m_started = 0;
                        m_grant_cyc = m_cyc;
                    end
                end
            end else if (tx_done) begin
                m_inflight = 0;
            end else if (!m_started) begin
                if (tx_busy) m_started = 1;
                else if (m_cyc - m_grant_cyc == BT) begin
                    e_terr = 1;
                    m_inflight = 0;
                end
            end
            e_abusy = m_inflight;
        end
    endtask

    task automatic check(input string name, input logic [NR-1:0] xa, input logic xs,
                         input logic [DW-1:0] xd, input logic [1:0] xg,
                         input logic xb, input logic xt);
        n_vec++;
        if (req_ack !== xa || tx_start !== xs || tx_data !== xd || grant_id !== xg ||
            arb_busy !== xb || timeout_err !== xt) begin
            n_err++;
            $display("FAIL %s: got ack=%b start=%b data=%h gid=%0d busy=%b terr=%b; want ack=%b start=%b data=%h gid=%0d busy=%b terr=%b",
                     name, req_ack, tx_start, tx_data, grant_id, arb_busy, timeout_err,
                     xa, xs, xd, xg, xb, xt);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic tick_m(input string name);
        tick();
        check(name, e_ack, e_start, e_data, e_gid, e_abusy, e_terr);
    endtask

    typedef struct {
        logic          rst;
        logic [NR-1:0] v;
        logic          bsy;
        logic          dn;
        logic [NR-1:0] xa;
        logic          xs;
        logic [DW-1:0] xd;
        logic [1:0]    xg;
        logic          xb;
        logic          xt;
    } vec_t;

    vec_t tbl[19];

    initial begin
        logic [DW-1:0] b;
        int seen;
        int starts;

        tbl[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 8'hA5, 2'd2, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 4'b1001, 1'b0, 1'b0, 4'b1000, 1'b1, 8'h44, 2'd3, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h44, 2'd3, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h44, 2'd3, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 4'b1001, 1'b0, 1'b0, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 4'b1001, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h11, 2'd0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 4'b1001, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h11, 2'd0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 4'b1001, 1'b1, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 4'b1001, 1'b0, 1'b0, 4'b1000, 1'b1, 8'h44, 2'd3, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 8'h44, 2'd3, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 4'b1001, 1'b0, 1'b0, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h11, 2'd0, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 4'b1010, 1'b0, 1'b0, 4'b0010, 1'b1, 8'h22, 2'd1, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h22, 2'd1, 1'b0, 1'b0};

        req_data = 32'h44A5_2211;
        for (int i = 0; i < 19; i++) begin
            reset = tbl[i].rst; req_valid = tbl[i].v; tx_busy = tbl[i].bsy; tx_done = tbl[i].dn;
            tick();
            check($sformatf("tbl%0d", i), tbl[i].xa, tbl[i].xs, tbl[i].xd, tbl[i].xg, tbl[i].xb, tbl[i].xt);
        end
        tx_busy = 0; tx_done = 0; req_valid = '0;

        // Single requester with a 10-cycle frame.
        reset = 1; tick_m("single_rst"); reset = 0;
        b = DW'($urandom);
        req_data = {8'h00, b, 16'h0000};
        req_valid = 4'b0100;
        tick();
        check("single_grant", 4'b0100, 1'b1, b, 2'd2, 1'b1, 1'b0);
        req_valid = '0; tx_busy = 1;
        for (int i = 0; i < 10; i++) tick_m("single_busy");
        tx_busy = 0; tx_done = 1;
        tick();
        check("single_done", 4'b0000, 1'b0, b, 2'd2, 1'b0, 1'b0);
        tx_done = 0;

        // Fairness: all requesters hold valid; grants must rotate 0,1,2,3,0,1.
        reset = 1; tick_m("fair_rst"); reset = 0;
        req_data = 32'hD3C2_B1A0; req_valid = 4'b1111; starts = 0;
        for (int f = 0; f < 6; f++) begin
            tick_m("fair_cycle");
            if (tx_start === 1'b1) starts++;
            n_vec++;
            if (tx_start !== 1'b1 || grant_id !== 2'(f % 4)) begin
                n_err++;
                $display("FAIL fair_order%0d: got start=%b gid=%0d; want start=1 gid=%0d", f, tx_start, grant_id, f % 4);
            end
            tx_busy = 1;
            for (int i = 0; i < 3; i++) begin
                tick_m("fair_busy");
                if (tx_start === 1'b1) starts++;
            end
            tx_busy = 0; tx_done = 1;
            tick_m("fair_done");
            if (tx_start === 1'b1) starts++;
            tx_done = 0;
        end
        n_vec++;
        if (starts != 6) begin
            n_err++;
            $display("FAIL fair_starts: got %0d tx_start pulses; want 6", starts);
        end
        req_valid = '0;
        tx_busy = 1; tick_m("fair_drain"); tx_busy = 0; tx_done = 1; tick_m("fair_drain"); tx_done = 0;

        // Timeout: busy never rises, error must appear BT cycles after the grant edge.
        reset = 1; tick_m("to_rst"); reset = 0;
        req_data = 32'h0000_0000 | 32'h0077_0000; req_valid = 4'b0100;
        tick_m("to_grant");
        req_valid = '0; seen = -1;
        for (int k = 1; k <= int'(BT) + 3; k++) begin
            tick_m("to_wait");
            if (timeout_err === 1'b1 && seen < 0) seen = k;
        end
        n_vec++;
        if (seen != int'(BT)) begin
            n_err++;
            $display("FAIL to_latency: got timeout_err at cycle %0d; want %0d", seen, BT);
        end
        req_data = 32'h0000_0055; req_valid = 4'b0001;
        tick();
        check("to_next_served", 4'b0001, 1'b1, 8'h55, 2'd0, 1'b1, 1'b0);
        req_valid = '0; tx_done = 1; tick_m("to_done"); tx_done = 0;

        // Randomized traffic, alternating windows that allow/suppress timeouts.
        for (int c = 0; c < 2000; c++) begin
            reset     = ($urandom_range(0, 79) == 0);
            req_valid = NR'($urandom);
            req_data  = $urandom;
            if (((c / 200) % 2) == 1) begin
                tx_busy = ($urandom_range(0, 19) == 0);
                tx_done = ($urandom_range(0, 24) == 0);
            end else begin
                tx_busy = 1'($urandom_range(0, 1));
                tx_done = ($urandom_range(0, 4) == 0);
            end
            tick_m("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
